irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Interrupt arbiter in front of the `cp0` block. It collects up to eight external interrupt request lines, latches rising edges as pending, and selects the highest-priority enabled source. It drives the 3-bit level that `cp0` compares against its current ring (`interruptSignal`). It also tracks nested in-service levels across acknowledge and ERET, so a source is never re-presented at or below the level currently being serviced. Software configures it through a small register port written and read like CP0 registers.

## Interface
Parameters:
- `N_SRC`, 8 — number of request lines; fixed at 8 so `irq_id` fits 3 bits.

Ports:
- `clk`  in  1  main clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_en`  in  1  pipeline advance enable; low freezes FSM and level stack.
- `irq_in`  in  N_SRC  raw asynchronous request lines, rising-edge triggered.
- `cfg_we`  in  1  config write strobe.
- `cfg_addr`  in  2  register select.
- `cfg_wdata`  in  32  config write data.
- `cfg_rdata`  out  32  registered read data for `cfg_addr`.
- `irq_ack`  in  1  one-cycle pulse: `cp0` has taken the presented interrupt.
- `eret`  in  1  one-cycle pulse: `cp0` executed ERET.
- `irq_level`  out  3  level presented to `cp0`: 0 = none, 1..3 = priority.
- `irq_id`  out  3  source index behind `irq_level`; valid when `irq_level != 0`.
- `cur_level`  out  2  level currently in service; 0 = user.

## Operation
Config registers:
- Addr 0, ENABLE[7:0]: read/write.
- Addr 1, PRIO[15:0]: read/write; source i uses bits [2i+1:2i]; value 0 disables the source.
- Addr 2, PENDING[7:0]: read; writing 1 to a bit clears it.
- Addr 3, STATUS: read-only; {stack[5:0], cur_level[1:0]} in bits [7:0]; writes are ignored.
- Unused bits read 0.

Request capture and selection:
- Each `irq_in` bit passes through a 2-flop synchronizer plus a delay flop. `sync2 & ~sync3` sets PENDING[i].
- A source is a candidate when PENDING & ENABLE & (PRIO != 0).
- Winner: highest PRIO; ties go to the lowest index.
- Present only when winner PRIO > `cur_level`.

Level stack:
- 3 entries × 2 bits, plus `cur_level`.
- Nesting is strictly increasing (levels 1..3), so the stack cannot overflow.

FSM:
- IDLE: `irq_level` = 0. Go to ASSERT when a presentable winner exists.
- ASSERT: `irq_level`/`irq_id` are registered from the winner and re-evaluated every cycle, so a higher winner replaces a lower one. Return to IDLE if the winner disappears or is no longer presentable.
  - On `irq_ack`: clear PENDING[`irq_id`], push `cur_level`, set `cur_level` to the presented level, go to BLANK.
- BLANK: `irq_level` forced 0 for 2 cycles, giving `cp0` time to update its ring, then IDLE.
- `eret` in any state: pop the stack into `cur_level` and return to IDLE after the current cycle. If the stack is empty, `cur_level` is set to 0.

Boundary rules:
- Edge and PENDING clear-by-ack on the same bit in the same cycle: set wins and the bit stays pending.
- Software write-1-clear and edge on the same bit in the same cycle: set wins.
- `irq_ack` outside ASSERT: ignored.
- `irq_ack` and `eret` in the same cycle: `eret` is ignored.
- `cpu_en` = 0: FSM, stack and `cur_level` hold. Synchronizers, PENDING capture and config writes continue.
- Changing PRIO/ENABLE while in ASSERT takes effect on the next selection cycle.

## Timing
- Reset: all registers 0. `irq_level` = 0, `irq_id` = 0, `cur_level` = 0, `cfg_rdata` = 0, FSM in IDLE, stack empty.
- `irq_in` sampled high at edge k:
  - sync2 at k+1.
  - PENDING set at k+2.
  - `irq_level` valid after edge k+3, giving 3-cycle latency.
- `cfg_rdata` is updated on the edge after `cfg_addr` is presented. Reads see the effect of a write one cycle later.
- `irq_level` is 0 for exactly 2 cycles after the ack edge, then re-evaluates.
- `eret` takes effect on the edge where it is sampled. A pending lower-level source is presented 1 cycle later.

## Structure
- Shared package `irq_pkg`:
  - register address constants `IRQ_ENABLE`, `IRQ_PRIO`, `IRQ_PENDING`, `IRQ_STATUS`.
  - FSM state enum {IDLE, ASSERT, BLANK}.
  - `N_SRC` default.
- Sub-module `irq_prio_sel`: combinational winner select (8 × 2-bit PRIO + candidate mask → level, id). This is the natural split. Everything else stays in `irq_arbiter`.

## Test plan
- ENABLE=0x01, PRIO=0x0002, pulse `irq_in[0]` → `irq_level`=2, `irq_id`=0 three cycles after sampling. `irq_ack` → PENDING=0, `cur_level`=2, `irq_level` 0 for 2 cycles.
- Sources 1 and 5 both PRIO 3, simultaneous edges → `irq_id`=1 first. After ack and `eret`, `irq_id`=5 is presented.
- Nesting: service level 1 (source 2), then edge on source 4 at level 3 → presented and acked, stack = {0,1}. Two `eret` pulses → `cur_level` 3→1→0.
- Source at level 1 pending while `cur_level`=2 → `irq_level` stays 0 until `eret`, then `irq_level`=1.
- Same-cycle `irq_ack` and new edge on the acked source → PENDING bit remains 1, re-presented after BLANK. Write 0x01 to PENDING concurrent with an edge on bit 0 → bit stays 1.
- Assert `rst_n` low mid-ASSERT with pending bits set → all outputs, PENDING and stack are 0 immediately. `cpu_en`=0 during `irq_ack` → no state change.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt arbiter.
//   N_SRC        number of request lines (fixed at 8 so a source id fits 3 bits)
//   IRQ_*        config register addresses
//   irq_state_e  arbiter FSM states
package irq_pkg;

    localparam int unsigned N_SRC  = 8;
    localparam int unsigned PRIO_W = 2;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned LVL_W  = 3;
    localparam int unsigned STK_W  = 6;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] IRQ_ENABLE  = 2'd0;
    localparam logic [ADDR_W-1:0] IRQ_PRIO    = 2'd1;
    localparam logic [ADDR_W-1:0] IRQ_PENDING = 2'd2;
    localparam logic [ADDR_W-1:0] IRQ_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        BLANK  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational winner select: highest non-zero priority among candidates,
// ties resolved toward the lowest source index.
//   prio        packed 2-bit priority per source
//   cand        candidate mask (pending & enabled)
//   win_prio_c  winning priority, 0 when no candidate
//   win_id_c    index of the winning source
module irq_prio_sel
    import irq_pkg::*;
(
    input  logic [PRIO_W*N_SRC-1:0] prio,
    input  logic [N_SRC-1:0]        cand,
    output logic [PRIO_W-1:0]       win_prio_c,
    output logic [ID_W-1:0]         win_id_c
);

    // Scan from the top index down; ">=" lets a lower index take over a tie.
    always_comb begin
        win_prio_c = '0;
        win_id_c   = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (cand[i] && (prio[PRIO_W*i +: PRIO_W] != '0) &&
                (prio[PRIO_W*i +: PRIO_W] >= win_prio_c)) begin
                win_prio_c = prio[PRIO_W*i +: PRIO_W];
                win_id_c   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter in front of cp0: edge capture, priority select, nested
// in-service level tracking and a CP0-style config register port.
//   clk, rst_n           clock, async active-low reset
//   cpu_en               pipeline advance; low freezes FSM and level stack
//   irq_in               raw asynchronous request lines (rising-edge)
//   cfg_we/addr/wdata    config write port; cfg_rdata registered read data
//   irq_ack, eret        cp0 handshakes (one-cycle pulses)
//   irq_level, irq_id    presented level (0 = none) and its source
//   cur_level            level currently in service
module irq_arbiter
    import irq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_en,
    input  logic [N_SRC-1:0]     irq_in,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [DATA_W-1:0]    cfg_wdata,
    output logic [DATA_W-1:0]    cfg_rdata,
    input  logic                 irq_ack,
    input  logic                 eret,
    output logic [LVL_W-1:0]     irq_level,
    output logic [ID_W-1:0]      irq_id,
    output logic [PRIO_W-1:0]    cur_level
);

    logic [N_SRC-1:0]        sync1_q, sync2_q, sync3_q, rise_c;
    logic [N_SRC-1:0]        enable_q, pending_q, pending_d;
    logic [PRIO_W*N_SRC-1:0] prio_q;
    logic [DATA_W-1:0]       rdata_c;
    logic [PRIO_W-1:0]       win_prio_c;
    logic [ID_W-1:0]         win_id_c;
    logic                    present_c, ack_take_c;

    irq_state_e              state_q, state_d;
    logic [LVL_W-1:0]        irq_level_d;
    logic [ID_W-1:0]         irq_id_d;
    logic [PRIO_W-1:0]       cur_level_d;
    logic [STK_W-1:0]        stack_q, stack_d;
    logic                    blank_cnt_q, blank_cnt_d;
    logic                    unused_wdata_c;

    assign unused_wdata_c = ^cfg_wdata[DATA_W-1:2*N_SRC];

    // Synchronizer plus delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise_c = sync2_q & ~sync3_q;

    irq_prio_sel u_sel (
        .prio       (prio_q),
        .cand       (pending_q & enable_q),
        .win_prio_c (win_prio_c),
        .win_id_c   (win_id_c)
    );

    assign present_c = (win_prio_c > cur_level);

    // Pending: clears first, new edges applied last so a set always wins
    always_comb begin
        pending_d = pending_q;
        if (cfg_we && (cfg_addr == IRQ_PENDING)) begin
            pending_d = pending_d & ~cfg_wdata[N_SRC-1:0];
        end
        if (ack_take_c) begin
            pending_d[irq_id] = 1'b0;
        end
        pending_d = pending_d | rise_c;
    end

    // Config read mux; unused bits read 0
    always_comb begin
        rdata_c = '0;
        case (cfg_addr)
            IRQ_ENABLE:  rdata_c = DATA_W'(enable_q);
            IRQ_PRIO:    rdata_c = DATA_W'(prio_q);
            IRQ_PENDING: rdata_c = DATA_W'(pending_q);
            IRQ_STATUS:  rdata_c = DATA_W'({stack_q, cur_level});
            default:     rdata_c = '0;
        endcase
    end

    // Config registers and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q  <= '0;
            prio_q    <= '0;
            pending_q <= '0;
            cfg_rdata <= '0;
        end else begin
            pending_q <= pending_d;
            cfg_rdata <= rdata_c;
            if (cfg_we && (cfg_addr == IRQ_ENABLE)) enable_q <= cfg_wdata[N_SRC-1:0];
            if (cfg_we && (cfg_addr == IRQ_PRIO))   prio_q   <= cfg_wdata[PRIO_W*N_SRC-1:0];
        end
    end

    // FSM next state, presented level and level stack (top entry in [1:0])
    always_comb begin
        state_d     = state_q;
        irq_level_d = irq_level;
        irq_id_d    = irq_id;
        cur_level_d = cur_level;
        stack_d     = stack_q;
        blank_cnt_d = blank_cnt_q;
        ack_take_c  = 1'b0;
        if (cpu_en) begin
            ack_take_c = (state_q == ASSERT) && irq_ack;
            unique case (state_q)
                IDLE, ASSERT: begin
                    if (ack_take_c) begin
                        state_d     = BLANK;
                        blank_cnt_d = 1'b0;
                        irq_level_d = '0;
                        stack_d     = {stack_q[STK_W-PRIO_W-1:0], cur_level};
                        cur_level_d = irq_level[PRIO_W-1:0];
                    end else if (present_c) begin
                        state_d     = ASSERT;
                        irq_level_d = LVL_W'(win_prio_c);
                        irq_id_d    = win_id_c;
                    end else begin
                        state_d     = IDLE;
                        irq_level_d = '0;
                    end
                end
                BLANK: begin
                    irq_level_d = '0;
                    if (blank_cnt_q) begin
                        if (present_c) begin
                            state_d     = ASSERT;
                            irq_level_d = LVL_W'(win_prio_c);
                            irq_id_d    = win_id_c;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        blank_cnt_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    irq_level_d = '0;
                end
            endcase
            // ERET pops; an empty stack shifts in 0 so cur_level drops to user
            if (eret && !ack_take_c) begin
                state_d     = IDLE;
                irq_level_d = '0;
                blank_cnt_d = 1'b0;
                cur_level_d = stack_q[PRIO_W-1:0];
                stack_d     = {PRIO_W'(0), stack_q[STK_W-1:PRIO_W]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            irq_level   <= '0;
            irq_id      <= '0;
            cur_level   <= '0;
            stack_q     <= '0;
            blank_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_level   <= irq_level_d;
            irq_id      <= irq_id_d;
            cur_level   <= cur_level_d;
            stack_q     <= stack_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: a behavioural model advanced on every
// clock edge and compared against the DUT each cycle, plus literal checks.
module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_en = 1'b1;
    logic [7:0]  irq_in = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        irq_ack = 1'b0;
    logic        eret = 1'b0;
    logic [2:0]  irq_level;
    logic [2:0]  irq_id;
    logic [1:0]  cur_level;

    int tests = 0;
    int fails = 0;

    irq_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_en    (cpu_en),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_ack   (irq_ack),
        .eret      (eret),
        .irq_level (irq_level),
        .irq_id    (irq_id),
        .cur_level (cur_level)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_PRES = 1, M_BLANK = 2;
    logic [7:0]  h0, h1, h2;      // irq_in sampled 1, 2, 3 edges ago
    logic [7:0]  m_en, m_pend;
    int          m_pr[8];
    int          m_stk[$];
    int          m_cur, m_lvl, m_id, m_mode, m_blank;
    logic [31:0] m_rd;

    task automatic model_reset();
        h0 = '0; h1 = '0; h2 = '0;
        m_en = '0; m_pend = '0;
        for (int i = 0; i < 8; i++) m_pr[i] = 0;
        m_stk.delete();
        m_cur = 0; m_lvl = 0; m_id = 0; m_mode = M_IDLE; m_blank = 0; m_rd = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: v = 32'(m_en);
            2'd1: for (int i = 0; i < 8; i++) v = v | (32'(m_pr[i]) << (2 * i));
            2'd2: v = 32'(m_pend);
            default: begin
                v = 32'(m_cur);
                for (int j = 0; j < m_stk.size(); j++)
                    v = v | (32'(m_stk[m_stk.size() - 1 - j]) << (2 + 2 * j));
            end
        endcase
        return v;
    endfunction

    task automatic model_step();
        logic [7:0] rise;
        int wp, wi;
        bit ack_ok, eret_ok;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise = h1 & ~h2;
        h2 = h1; h1 = h0; h0 = irq_in;
        wp = 0; wi = 0;
        for (int i = 0; i < 8; i++)
            if (m_pend[i] && m_en[i] && m_pr[i] > wp) begin
                wp = m_pr[i]; wi = i;
            end
        m_rd = model_read(cfg_addr);
        ack_ok  = cpu_en && (m_mode == M_PRES) && irq_ack;
        eret_ok = cpu_en && eret && !ack_ok;
        if (cfg_we && cfg_addr == 2'd2) m_pend = m_pend & ~cfg_wdata[7:0];
        if (ack_ok) m_pend[m_id] = 1'b0;
        m_pend = m_pend | rise;
        if (cpu_en) begin
            if (eret_ok) begin
                if (m_stk.size() > 0) m_cur = m_stk.pop_back();
                else m_cur = 0;
                m_mode = M_IDLE; m_lvl = 0;
            end else if (ack_ok) begin
                m_stk.push_back(m_cur);
                m_cur = m_lvl; m_lvl = 0;
                m_mode = M_BLANK; m_blank = 2;
            end else if (m_mode == M_BLANK && m_blank > 1) begin
                m_blank--;
            end else if (wp > m_cur) begin
                m_mode = M_PRES; m_lvl = wp; m_id = wi;
            end else begin
                m_mode = M_IDLE; m_lvl = 0;
            end
        end
        if (cfg_we && cfg_addr == 2'd0) m_en = cfg_wdata[7:0];
        if (cfg_we && cfg_addr == 2'd1)
            for (int i = 0; i < 8; i++) m_pr[i] = int'(cfg_wdata[2*i +: 2]);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("model irq_level", 32'(irq_level), 32'(m_lvl));
        if (m_lvl != 0) check("model irq_id", 32'(irq_id), 32'(m_id));
        check("model cur_level", 32'(cur_level), 32'(m_cur));
        check("model cfg_rdata", cfg_rdata, m_rd);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq_in = m; tick(); irq_in = '0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1; tick(); eret = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        ticks(2);
        check("reset irq_level", 32'(irq_level), 32'd0);
        check("reset irq_id", 32'(irq_id), 32'd0);
        check("reset cur_level", 32'(cur_level), 32'd0);
        check("reset cfg_rdata", cfg_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Ack outside ASSERT is ignored
        do_ack();
        check("idle ack cur_level", 32'(cur_level), 32'd0);

        // Basic latency, ack, blank
        cfg_write(2'd0, 32'h01);
        cfg_write(2'd1, 32'h0002);
        pulse_irq(8'h01);
        ticks(2);
        check("t1 level before k+3", 32'(irq_level), 32'd0);
        tick();
        check("t1 level k+3", 32'(irq_level), 32'd2);
        check("t1 id k+3", 32'(irq_id), 32'd0);
        cfg_addr = 2'd2;
        do_ack();
        check("t1 cur after ack", 32'(cur_level), 32'd2);
        check("t1 level blank0", 32'(irq_level), 32'd0);
        tick();
        check("t1 pending cleared", cfg_rdata, 32'd0);
        tick();
        do_eret();
        check("t1 cur after eret", 32'(cur_level), 32'd0);

        // Tie on priority 3: lower index first, higher after eret
        cfg_write(2'd0, 32'h22);
        cfg_write(2'd1, 32'h0C0C);
        pulse_irq(8'h22);
        ticks(3);
        check("t2 level", 32'(irq_level), 32'd3);
        check("t2 tie id", 32'(irq_id), 32'd1);
        do_ack();
        ticks(3);
        check("t2 not above cur", 32'(irq_level), 32'd0);
        do_eret();
        check("t2 eret cur", 32'(cur_level), 32'd0);
        check("t2 eret level", 32'(irq_level), 32'd0);
        tick();
        check("t2 second id", 32'(irq_id), 32'd5);
        check("t2 second level", 32'(irq_level), 32'd3);
        do_ack();
        do_eret();

        // Nesting: level 1 then level 3, stack readback, two erets
        cfg_write(2'd0, 32'h14);
        cfg_write(2'd1, 32'h0310);
        pulse_irq(8'h04);
        ticks(3);
        check("t3 level1 id", 32'(irq_id), 32'd2);
        do_ack();
        check("t3 cur 1", 32'(cur_level), 32'd1);
        ticks(2);
        pulse_irq(8'h10);
        ticks(3);
        check("t3 level3", 32'(irq_level), 32'd3);
        check("t3 level3 id", 32'(irq_id), 32'd4);
        cfg_addr = 2'd3;
        do_ack();
        tick();
        check("t3 status", cfg_rdata, 32'h07);
        do_eret();
        check("t3 eret1 cur", 32'(cur_level), 32'd1);
        do_eret();
        check("t3 eret2 cur", 32'(cur_level), 32'd0);

        // Lower level held back until eret
        cfg_write(2'd0, 32'h09);
        cfg_write(2'd1, 32'h0042);
        pulse_irq(8'h01);
        ticks(3);
        do_ack();
        pulse_irq(8'h08);
        ticks(5);
        check("t4 masked by cur", 32'(irq_level), 32'd0);
        do_eret();
        check("t4 eret cur", 32'(cur_level), 32'd0);
        tick();
        check("t4 presented level", 32'(irq_level), 32'd1);
        check("t4 presented id", 32'(irq_id), 32'd3);
        do_ack();
        do_eret();

        // Ack and edge on same bit; write-1-clear and edge on same bit
        cfg_write(2'd0, 32'h01);
        cfg_write(2'd1, 32'h0002);
        pulse_irq(8'h01);
        ticks(3);
        pulse_irq(8'h01);
        tick();
        cfg_addr = 2'd2;
        do_ack();
        tick();
        check("t5 ack vs edge pending", cfg_rdata, 32'h01);
        tick();
        do_eret();
        tick();
        check("t5 re-presented", 32'(irq_level), 32'd2);
        do_ack();
        do_eret();
        pulse_irq(8'h01);
        tick();
        cfg_write(2'd2, 32'h01);
        tick();
        check("t5 w1c vs edge pending", cfg_rdata, 32'h01);
        check("t5 w1c vs edge level", 32'(irq_level), 32'd2);
        cfg_write(2'd2, 32'h01);
        tick();
        check("t5 w1c withdraws", 32'(irq_level), 32'd0);
        check("t5 w1c pending", cfg_rdata, 32'd0);

        // Asynchronous reset mid-ASSERT with nested state
        cfg_write(2'd0, 32'h11);
        cfg_write(2'd1, 32'h0302);
        pulse_irq(8'h01);
        ticks(3);
        do_ack();
        ticks(2);
        pulse_irq(8'h10);
        ticks(3);
        check("t6 pre-reset level", 32'(irq_level), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t6 async irq_level", 32'(irq_level), 32'd0);
        check("t6 async irq_id", 32'(irq_id), 32'd0);
        check("t6 async cur_level", 32'(cur_level), 32'd0);
        check("t6 async cfg_rdata", cfg_rdata, 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        cfg_addr = 2'd2;
        tick();
        check("t6 pending after reset", cfg_rdata, 32'd0);
        cfg_addr = 2'd3;
        tick();
        check("t6 status after reset", cfg_rdata, 32'd0);

        // cpu_en low freezes ack
        cfg_write(2'd0, 32'h01);
        cfg_write(2'd1, 32'h0002);
        pulse_irq(8'h01);
        ticks(3);
        cpu_en = 1'b0;
        do_ack();
        cpu_en = 1'b1;
        check("t7 frozen level", 32'(irq_level), 32'd2);
        check("t7 frozen cur", 32'(cur_level), 32'd0);
        tick();
        do_ack();
        check("t7 ack cur", 32'(cur_level), 32'd2);
        do_eret();
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
